// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the bin_div producer, the BCD converter and the
// display/report consumer.
interface div_result_bcd_if #(
  parameter int QW = 16,
  parameter int RW = 17,
  parameter int QD = 5,
  parameter int RD = 6
);
  logic              in_valid;
  logic [QW-1:0]     quot;
  logic [RW-1:0]     rem;
  logic              in_ready;
  logic              busy;
  logic              out_valid;
  logic              out_ack;
  logic [4*QD-1:0]   q_bcd;
  logic [4*RD-1:0]   r_bcd;

  modport master (
    output in_valid, quot, rem, out_ack,
    input  in_ready, busy, out_valid, q_bcd, r_bcd
  );

  modport slave (
    input  in_valid, quot, rem, out_ack,
    output in_ready, busy, out_valid, q_bcd, r_bcd
  );
endinterface

// File: rtl/div_result_bcd.sv
// Sequential binary-to-BCD converter for a quotient/remainder pair using
// shift-and-add-3, one bit per clock, with a valid/ack result handshake.
module div_result_bcd #(
  parameter int QW = 16,
  parameter int RW = 17,
  parameter int QD = 5,
  parameter int RD = 6
) (
  input  logic             clk,
  input  logic             rst,
  div_result_bcd_if.slave  bus
);

  localparam int CW = $clog2(RW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     qbin, rbin;
  logic [4*QD-1:0]   qacc, qadj, qacc_nxt, qout;
  logic [4*RD-1:0]   racc, radj, racc_nxt, rout;
  logic [CW-1:0]     cnt;
  logic              last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    last      = (cnt == CW'(RW - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ack)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == SHIFT);
    bus.out_valid = (state == DONE);
    bus.q_bcd     = qout;
    bus.r_bcd     = rout;
  end

  // Digit correction precedes the shift so the shifted-in bit never carries
  // a digit past 9.
  always_comb begin
    qadj = qacc;
    for (int unsigned i = 0; i < QD; i++)
      if (qacc[4*i +: 4] >= 4'd5) qadj[4*i +: 4] = qacc[4*i +: 4] + 4'd3;
    radj = racc;
    for (int unsigned i = 0; i < RD; i++)
      if (racc[4*i +: 4] >= 4'd5) radj[4*i +: 4] = racc[4*i +: 4] + 4'd3;
    qacc_nxt = (qadj << 1) | {{(4*QD-1){1'b0}}, qbin[RW-1]};
    racc_nxt = (radj << 1) | {{(4*RD-1){1'b0}}, rbin[RW-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qbin <= '0;
      rbin <= '0;
      qacc <= '0;
      racc <= '0;
      cnt  <= '0;
      qout <= '0;
      rout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            qbin <= RW'(bus.quot);
            rbin <= bus.rem;
            qacc <= '0;
            racc <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          qbin <= qbin << 1;
          rbin <= rbin << 1;
          qacc <= qacc_nxt;
          racc <= racc_nxt;
          cnt  <= cnt + CW'(1);
          // Published outputs only move here, so the previous result stays
          // visible while the next conversion is running.
          if (last) begin
            qout <= qacc_nxt;
            rout <= racc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
